// File: rtl/stream_source.sv
// Word-stream producer: holds input words in a local RAM loaded through a write
// port and streams them in address order over a valid/ready handshake.
module stream_source #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   num_words,
  input  logic                 start,
  input  logic                 data_ready,
  output logic [WORD_SIZE-1:0] data,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE:0]   words_sent
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  state_t               state, state_n;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_pending;
  logic [WORD_SIZE-1:0] skid_data, skid_data_n;
  logic                 skid_valid, skid_valid_n;
  logic [WORD_SIZE-1:0] data_n;
  logic                 data_valid_n, busy_n, done_n;
  logic [CW-1:0]        count, count_n, rd_addr, rd_addr_n, words_sent_n, clamp_c;
  logic                 rd_en_c, xfer_c, out_free_c, last_c;
  logic [ADDR_SIZE-1:0] rd_idx_c;
  logic [1:0]           occ_c;

  // Word memory: writes only while not streaming, 1-cycle synchronous read
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE || state == DONE)) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en_c) begin
      rd_data <= mem[rd_idx_c];
    end
  end

  // Next-state and datapath. Capacity ahead of the consumer is two words
  // (output register + skid); a read is only issued if its word has a slot.
  always_comb begin
    state_n      = state;
    data_n       = data;
    data_valid_n = data_valid;
    skid_data_n  = skid_data;
    skid_valid_n = skid_valid;
    count_n      = count;
    rd_addr_n    = rd_addr;
    words_sent_n = words_sent;
    rd_en_c      = 1'b0;
    rd_idx_c     = rd_addr[ADDR_SIZE-1:0];
    xfer_c       = data_valid & data_ready;
    out_free_c   = ~data_valid | xfer_c;
    last_c       = xfer_c && ((words_sent + CW'(1)) == count);
    occ_c        = 2'(data_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(xfer_c);
    clamp_c      = (num_words > CW'(DEPTH)) ? CW'(DEPTH) : num_words;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          words_sent_n = '0;
          if (num_words == '0) begin
            state_n = DONE;
          end else begin
            state_n   = PRIME;
            count_n   = clamp_c;
            rd_en_c   = 1'b1;
            rd_idx_c  = '0;
            rd_addr_n = CW'(1);
          end
        end
      end
      PRIME, STREAM: begin
        if (xfer_c) begin
          words_sent_n = words_sent + CW'(1);
        end
        if (last_c) begin
          state_n      = DONE;
          data_valid_n = 1'b0;
          skid_valid_n = 1'b0;
        end else begin
          state_n = STREAM;
          if (out_free_c) begin
            if (skid_valid) begin
              data_n       = skid_data;
              data_valid_n = 1'b1;
              skid_valid_n = 1'b0;
            end else if (rd_pending) begin
              data_n       = rd_data;
              data_valid_n = 1'b1;
            end else begin
              data_valid_n = 1'b0;
            end
          end else if (rd_pending) begin
            skid_data_n  = rd_data;
            skid_valid_n = 1'b1;
          end
          if ((rd_addr < count) && (occ_c <= 2'd1)) begin
            rd_en_c   = 1'b1;
            rd_addr_n = rd_addr + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == PRIME) || (state_n == STREAM);
    done_n = (state_n == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data       <= '0;
      data_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      rd_pending <= 1'b0;
      count      <= '0;
      rd_addr    <= '0;
      words_sent <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      skid_data  <= skid_data_n;
      skid_valid <= skid_valid_n;
      rd_pending <= rd_en_c;
      count      <= count_n;
      rd_addr    <= rd_addr_n;
      words_sent <= words_sent_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source against an array/queue reference model.
module tb_stream_source;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic [8:0]  num_words = '0;
  logic        start = 1'b0;
  logic        data_ready = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic [8:0]  words_sent;

  int checks = 0;
  int passes = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  bit          ready_pat[$];
  bit          noise_start = 1'b0;
  int          first_valid_cyc;
  int          valid_cycles;
  int          run_cycles;
  bit          timed_out;
  bit          stable_ok;

  stream_source dut (
    .clk(clk), .reset(reset), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .num_words(num_words), .start(start), .data_ready(data_ready), .data(data),
    .data_valid(data_valid), .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic load_mem(input bit rand_fill);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = rand_fill ? 16'($urandom) : 16'(i + 1);
      model_mem[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected stream: the first min(n, DEPTH) words of memory, in address order
  task automatic build_exp(input int n);
    int m;
    m = (n > DEPTH) ? DEPTH : n;
    exp_q.delete();
    for (int i = 0; i < m; i++) exp_q.push_back(model_mem[i]);
  endtask

  // Called at a negedge; the start pulse is sampled on the following posedge
  task automatic pulse_start(input int n);
    num_words = 9'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumer: one step per negedge until done, recording accepted words
  task automatic collect(input int ready_pct, input int max_cyc);
    bit          hold;
    logic [15:0] held;
    hold = 1'b0;
    held = '0;
    got_q.delete();
    stable_ok = 1'b1;
    timed_out = 1'b1;
    first_valid_cyc = -1;
    valid_cycles = 0;
    run_cycles = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done) begin
        timed_out = 1'b0;
        run_cycles = c;
        break;
      end
      if (data_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = c;
      end
      if (hold && (!data_valid || data !== held)) stable_ok = 1'b0;
      if (ready_pat.size() > 0) data_ready = ready_pat.pop_front();
      else data_ready = ($urandom_range(99) < ready_pct);
      if (noise_start) begin
        start = 1'($urandom);
        num_words = 9'($urandom);
      end
      if (data_valid && data_ready) got_q.push_back(data);
      hold = data_valid && !data_ready;
      held = data;
      @(negedge clk);
    end
    start = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", data_valid); else passes++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); else passes++;
    checks++; if (words_sent !== 9'd0 || data !== 16'd0) $display("FAIL reset_regs got ws=%0d data=%h exp 0", words_sent, data); else passes++;
    reset = 1'b0;
  endtask

  task automatic check_run(input string name, input int n);
    int bad;
    int m;
    m = (n > DEPTH) ? DEPTH : n;
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++; if (timed_out) $display("FAIL %s_timeout got=no_done exp=done", name); else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size()); else passes++;
    checks++;
    if (bad >= 0) $display("FAIL %s_data idx=%0d got=%h exp=%h", name, bad, got_q[bad], exp_q[bad]);
    else passes++;
    checks++; if (words_sent !== 9'(m)) $display("FAIL %s_words_sent got=%0d exp=%0d", name, words_sent, m); else passes++;
    checks++; if (!stable_ok) $display("FAIL %s_stall_stable got=changed exp=held", name); else passes++;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) $display("FAIL %s_end_flags got d=%b b=%b v=%b exp 1 0 0", name, done, busy, data_valid); else passes++;
  endtask

  task automatic test_full_stream;
    build_exp(200);
    pulse_start(200);
    collect(100, 400);
    check_run("full200", 200);
    checks++; if (first_valid_cyc != 1) $display("FAIL full200_latency got=%0d exp=1", first_valid_cyc); else passes++;
    checks++; if (valid_cycles != 200 || run_cycles != 201) $display("FAIL full200_throughput got vc=%0d rc=%0d exp 200 201", valid_cycles, run_cycles); else passes++;
  endtask

  task automatic test_backpressure;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    build_exp(4);
    pulse_start(4);
    collect(100, 100);
    check_run("stall4", 4);
  endtask

  task automatic test_zero;
    build_exp(0);
    pulse_start(0);
    collect(100, 20);
    check_run("zero", 0);
    checks++; if (run_cycles != 0 || valid_cycles != 0) $display("FAIL zero_timing got rc=%0d vc=%0d exp 0 0", run_cycles, valid_cycles); else passes++;
  endtask

  task automatic test_clamp;
    build_exp(300);
    pulse_start(300);
    collect(100, 600);
    check_run("clamp300", 300);
    checks++; if (valid_cycles != 256) $display("FAIL clamp300_cycles got=%0d exp=256", valid_cycles); else passes++;
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    pulse_start(10);
    data_ready = 1'b1;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      if (data_valid) seen++;
      @(negedge clk);
    end
    reset = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (seen != 3) $display("FAIL rstmid_pre got=%0d exp=3", seen); else passes++;
    checks++; if (data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_flags got v=%b b=%b d=%b exp 000", data_valid, busy, done); else passes++;
    build_exp(10);
    pulse_start(10);
    collect(70, 200);
    check_run("rstmid_rerun", 10);
  endtask

  task automatic test_write_lockout;
    logic [15:0] old5;
    old5 = model_mem[5];
    pulse_start(8);
    for (int c = 0; c < 3; c++) begin
      wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF;
      @(negedge clk);
    end
    wr_en = 1'b0;
    build_exp(8);
    collect(100, 100);
    check_run("wr_busy", 8);
    checks++; if (got_q.size() > 5 && got_q[5] !== old5) $display("FAIL wr_busy_word5 got=%h exp=%h", got_q[5], old5); else passes++;
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[5] = 16'hBEEF;
    build_exp(8);
    pulse_start(8);
    collect(100, 100);
    check_run("wr_done", 8);
    checks++; if (got_q.size() < 6 || got_q[5] !== 16'hBEEF) $display("FAIL wr_done_word5 got=%h exp=beef", (got_q.size() > 5) ? got_q[5] : 16'hxxxx); else passes++;
  endtask

  task automatic test_random;
    int n;
    load_mem(1'b1);
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 1 : int'($urandom_range(300, 1));
      build_exp(n);
      pulse_start(n);
      noise_start = (r % 2) == 1;
      collect(int'($urandom_range(100, 25)), 4000);
      noise_start = 1'b0;
      check_run($sformatf("rand%0d_n%0d", r, n), n);
    end
  endtask

  initial begin
    test_reset;
    load_mem(1'b0);
    test_full_stream;
    test_backpressure;
    test_zero;
    test_clamp;
    test_reset_mid;
    test_write_lockout;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
